// File: rtl/serial_receiver.sv
// Async serial receiver: start(0), 8 data bits MSB first, stop(1); byte delivered on valid/ack.
// Define RX_SYNC_EN to pass RxD through a 2-flop synchroniser (adds 2 cycles of latency).
module serial_receiver #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clks,
  input  logic       resets,
  input  logic       RxD,
  input  logic       rx_ack,
  output logic [7:0] char_received,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam bit SKIP_START = (HALF == 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       char_d;
  logic             valid_d, frame_err_d, overrun_d, busy_d;
  logic             rx_s;
  logic             cnt_zero;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser, reset to the idle line level.
  always_ff @(posedge clks or negedge resets) begin
    if (!resets) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], RxD};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = RxD;
`endif

  assign cnt_zero = (cnt_q == '0);

  // State register.
  always_ff @(posedge clks or negedge resets) begin
    if (!resets) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = SKIP_START ? S_DATA : S_START;
      end
      S_START: begin
        if (cnt_zero) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_zero && (bit_idx_q == 3'd7)) state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_zero) state_d = rx_s ? S_IDLE : S_BRK;
      end
      S_BRK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; a held-low line parks in S_BRK rather than decoding 0x00.
  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    char_d      = char_received;
    valid_d     = (rx_valid && rx_ack) ? 1'b0 : rx_valid;
    frame_err_d = 1'b0;
    overrun_d   = overrun;
    busy_d      = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_d     = SKIP_START ? CNT_RELOAD : CNT_HALF;
          bit_idx_d = 3'd0;
        end
      end
      S_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rx_s) begin
          cnt_d     = CNT_RELOAD;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shreg_d   = {shreg_q[6:0], rx_s};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = CNT_RELOAD;
        end
      end
      S_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s) begin
          if (!rx_valid || rx_ack) begin
            char_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
      S_BRK: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clks or negedge resets) begin
    if (!resets) begin
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shreg_q       <= 8'h00;
      char_received <= 8'h00;
      rx_valid      <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      char_received <= char_d;
      rx_valid      <= valid_d;
      frame_err     <= frame_err_d;
      overrun       <= overrun_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: one instance at 1 clock/bit, one at 4 clocks/bit.
module tb_serial_receiver;

`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clks = 1'b0;
  logic       resets;
  logic       rxd1, rxd4, ack1, ack4;
  logic [7:0] char1, char4;
  logic       valid1, valid4, ferr1, ferr4, ovr1, ovr4, busy1, busy4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clks = ~clks;

  serial_receiver #(.CLKS_PER_BIT(1)) dut1 (
    .clks(clks), .resets(resets), .RxD(rxd1), .rx_ack(ack1),
    .char_received(char1), .rx_valid(valid1), .frame_err(ferr1),
    .overrun(ovr1), .busy(busy1)
  );

  serial_receiver #(.CLKS_PER_BIT(4)) dut4 (
    .clks(clks), .resets(resets), .RxD(rxd4), .rx_ack(ack4),
    .char_received(char4), .rx_valid(valid4), .frame_err(ferr4),
    .overrun(ovr4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clks);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mk_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i+1] = b[7-i];
    fr[9] = stop;
    return fr;
  endfunction

  // One frame on the 1 clock/bit line; ends at the first cycle the byte should be visible.
  task automatic send1(input logic [7:0] b, input logic stop, input int ack_at,
                       output logic v_early, output int fe_seen);
    logic [9:0] fr;
    fr      = mk_frame(b, stop);
    v_early = 1'b0;
    fe_seen = 0;
    for (int j = 0; j < 10 + LAT; j++) begin
      rxd1 = (j < 10) ? fr[j] : 1'b1;
      ack1 = (j == ack_at);
      tick();
      if (j + 1 == 9 + LAT) v_early = valid1;
      fe_seen += int'(ferr1);
    end
    ack1 = 1'b0;
    rxd1 = 1'b1;
  endtask

  initial begin
    logic       v_early;
    logic       vbad;
    logic       busy_seen;
    logic [9:0] fr;
    int         fe_cnt;

    resets = 1'b0;
    rxd1 = 1'b1; rxd4 = 1'b1; ack1 = 1'b0; ack4 = 1'b0;
    #1;
    chk("reset_char", 32'(char1), 32'h00);
    chk("reset_valid", 32'(valid1), 32'h0);
    chk("reset_ferr", 32'(ferr1), 32'h0);
    chk("reset_ovr", 32'(ovr1), 32'h0);
    chk("reset_busy", 32'(busy1), 32'h0);
    tick(); tick();
    #2 resets = 1'b1;
    tick(); tick();

    // 0xA5 at one clock per bit, with latency edges
    send1(8'hA5, 1'b1, -1, v_early, fe_cnt);
    chk("a5_valid_early", 32'(v_early), 32'h0);
    chk("a5_valid", 32'(valid1), 32'h1);
    chk("a5_char", 32'(char1), 32'hA5);
    chk("a5_ferr", 32'(fe_cnt), 32'h0);
    chk("a5_ovr", 32'(ovr1), 32'h0);
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    chk("a5_acked", 32'(valid1), 32'h0);
    chk("a5_char_kept", 32'(char1), 32'hA5);

    // 0x3C at four clocks per bit: sample lands on cycle 38+LAT of the frame
    fr = mk_frame(8'h3C, 1'b1);
    vbad = 1'b0;
    for (int c = 0; c < 39 + LAT; c++) begin
      rxd4 = (c < 40) ? fr[c/4] : 1'b1;
      tick();
      if (c + 1 == 38 + LAT) chk("3c_valid_early", 32'(valid4), 32'h0);
      if (c + 1 < 38 + LAT && valid4) vbad = 1'b1;
    end
    chk("3c_no_early_valid", 32'(vbad), 32'h0);
    chk("3c_valid", 32'(valid4), 32'h1);
    chk("3c_char", 32'(char4), 32'h3C);
    rxd4 = 1'b1;
    ack4 = 1'b1; tick(); ack4 = 1'b0;
    chk("3c_acked", 32'(valid4), 32'h0);

    // One-cycle low glitch at four clocks per bit
    rxd4 = 1'b0; tick(); rxd4 = 1'b1;
    fe_cnt = 0; busy_seen = 1'b0; vbad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      fe_cnt += int'(ferr4);
      if (busy4) busy_seen = 1'b1;
      if (valid4) vbad = 1'b1;
    end
    chk("glitch_seen", 32'(busy_seen), 32'h1);
    chk("glitch_idle", 32'(busy4), 32'h0);
    chk("glitch_valid", 32'(vbad), 32'h0);
    chk("glitch_ferr", 32'(fe_cnt), 32'h0);

    // 0x81 with stop bit 0, then the line held low
    fr = mk_frame(8'h81, 1'b0);
    fe_cnt = 0; vbad = 1'b0;
    for (int j = 0; j < 30; j++) begin
      rxd1 = (j < 9) ? fr[j] : 1'b0;
      tick();
      fe_cnt += int'(ferr1);
      if (valid1) vbad = 1'b1;
    end
    chk("break_ferr_once", 32'(fe_cnt), 32'h1);
    chk("break_no_valid", 32'(vbad), 32'h0);
    chk("break_busy", 32'(busy1), 32'h1);
    rxd1 = 1'b1;
    repeat (LAT + 2) tick();
    chk("break_released", 32'(busy1), 32'h0);
    chk("break_valid_after", 32'(valid1), 32'h0);

    // Back-to-back 0x11, 0x22 without ack: overrun
    send1(8'h11, 1'b1, -1, v_early, fe_cnt);
    chk("ovr_first", 32'(char1), 32'h11);
    send1(8'h22, 1'b1, -1, v_early, fe_cnt);
    chk("ovr_char_kept", 32'(char1), 32'h11);
    chk("ovr_flag", 32'(ovr1), 32'h1);
    chk("ovr_valid", 32'(valid1), 32'h1);
    tick();
    chk("ovr_sticky", 32'(ovr1), 32'h1);

    // Same pair with ack on the second stop-sample cycle
    resets = 1'b0; #1;
    chk("rst2_ovr", 32'(ovr1), 32'h0);
    tick(); #2 resets = 1'b1; tick();
    send1(8'h11, 1'b1, -1, v_early, fe_cnt);
    send1(8'h22, 1'b1, 9 + LAT, v_early, fe_cnt);
    chk("ack_char", 32'(char1), 32'h22);
    chk("ack_valid", 32'(valid1), 32'h1);
    chk("ack_ovr", 32'(ovr1), 32'h0);

    // Reset during data bit 4, then a clean 0x5A
    fr = mk_frame(8'h5A, 1'b1);
    for (int j = 0; j < 5; j++) begin
      rxd1 = fr[j];
      tick();
    end
    rxd1 = fr[5];
    #2 resets = 1'b0;
    #1;
    chk("midrst_char", 32'(char1), 32'h00);
    chk("midrst_valid", 32'(valid1), 32'h0);
    chk("midrst_busy", 32'(busy1), 32'h0);
    chk("midrst_ferr", 32'(ferr1), 32'h0);
    chk("midrst_ovr", 32'(ovr1), 32'h0);
    tick();
    rxd1 = 1'b1;
    tick();
    #2 resets = 1'b1;
    repeat (3) tick();
    chk("midrst_quiet", 32'(valid1), 32'h0);
    send1(8'h5A, 1'b1, -1, v_early, fe_cnt);
    chk("5a_char", 32'(char1), 32'h5A);
    chk("5a_valid", 32'(valid1), 32'h1);
    chk("5a_ferr", 32'(fe_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Receive end of the team's async serial link. Deserialises the frame produced by the matching transmitter: start bit (0), 8 data bits MSB first, stop bit (1). Line idles high.
- Samples RxD at a configurable clocks-per-bit rate, checks the framing, and presents each byte on a valid/ack handshake to the downstream consumer.

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit; must be >= 1 (1 = one bit per clock, the transmitter's native rate).

Ports:
- clks  input  1  clock, all logic on rising edge
- resets  input  1  asynchronous, active-low reset
- RxD  input  1  serial line, idle high
- rx_ack  input  1  consumer accepts char_received when rx_valid=1
- char_received  output  8  last received byte
- rx_valid  output  1  char_received holds an unacknowledged byte
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  sticky: a byte was dropped because rx_valid was still 1
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (resets=0, async): state=IDLE, char_received=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, internal counters 0. Reset mid-frame abandons the frame; no output is produced for it.
- Notation: rx_s is the sampled line (RxD itself, or the synchronised copy; see Optional Feature). HALF = CLKS_PER_BIT/2 (integer division).
- State IDLE:
  - rx_s=0 and HALF=0 -> DATA with cnt=CLKS_PER_BIT-1, bit_idx=0.
  - rx_s=0 and HALF>0 -> START with cnt=HALF-1.
- State START: decrement cnt. At cnt=0:
  - rx_s=0 -> DATA with cnt=CLKS_PER_BIT-1, bit_idx=0.
  - rx_s=1 -> IDLE (false start, glitch rejected, no flags).
- State DATA: decrement cnt. At cnt=0:
  - Shift left: shreg <= {shreg[6:0], rx_s}, so the first data bit ends up as bit 7.
  - bit_idx++ and reload cnt=CLKS_PER_BIT-1.
  - After the 8th sample -> STOP.
- State STOP: at cnt=0, sample rx_s:
  - rx_s=1 and (rx_valid=0 or rx_ack=1) -> char_received<=shreg, rx_valid<=1, then IDLE.
  - rx_s=1 and rx_valid=1 and rx_ack=0 -> byte dropped, old byte kept, overrun<=1, then IDLE.
  - rx_s=0 -> frame_err pulses 1 for one cycle, no delivery, then BREAK.
- State BREAK: wait for rx_s=1, then IDLE. A held-low line is therefore never decoded as repeated 0x00 bytes.
- Handshake:
  - rx_valid falls on the edge after a cycle with rx_valid=1 and rx_ack=1, unless a new byte is delivered on that same edge; in that case it stays 1 with the new data.
  - rx_ack while rx_valid=0 is ignored.
  - overrun clears only on reset.
- Latency (CLKS_PER_BIT=1, no sync): first start-bit cycle k is detected in IDLE; data sampled k+1..k+8; stop sampled k+9; rx_valid and char_received visible from cycle k+10.
- Back-to-back frames: a start bit arriving in the cycle after the stop sample is detected, because IDLE is entered on that edge.

Optional Feature:
- Macro RX_SYNC_EN.
- Defined: RxD passes through a 2-flop synchroniser (both flops reset to 1) before use as rx_s. All latencies grow by 2 cycles; rx_valid is visible from k+12 in the latency example.
- Undefined: rx_s = RxD directly. Use only when RxD is generated in the clks domain.

Test Plan:
- CLKS_PER_BIT=1; drive RxD 0,1,0,1,0,0,1,0,1,1 starting at cycle k -> char_received=8'hA5, rx_valid=1 from k+10, frame_err=0, overrun=0.
- CLKS_PER_BIT=4; frame for 8'h3C, each bit held 4 cycles -> samples land at cycles 2,6,10,... of the frame; char_received=8'h3C. A 1-cycle low glitch on an idle line -> back to IDLE, no rx_valid, no frame_err.
- Frame for 8'h81 with stop bit 0, then RxD held low 20 cycles -> frame_err high for exactly 1 cycle, rx_valid stays 0, busy high until RxD returns to 1, no further bytes decoded.
- Two frames 8'h11 then 8'h22 with no rx_ack -> char_received stays 8'h11, overrun=1. Repeat with rx_ack=1 on the stop-sample cycle of the second frame -> char_received=8'h22, rx_valid stays 1, overrun=0.
- Assert resets=0 during data bit 4 of a frame, release, then send 8'h5A -> all outputs at reset values during reset; next byte received is 8'h5A.
- Build with RX_SYNC_EN, repeat the first test -> same data, rx_valid from k+12.
